// File: rtl/ha_token_pipe.sv
// Elastic valid/ready token stage: DEPTH-slot circular buffer with occupancy report and flush.
// Optional statistics outputs are compiled in when HA_TOKEN_PIPE_STATS_EN is defined.
module ha_token_pipe #(
    parameter int DATA_BW = 32,
    parameter int DEPTH   = 4,
    localparam int CNT_BW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_BW-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_BW-1:0] out_data,
    output logic [CNT_BW-1:0]  occupancy
`ifdef HA_TOKEN_PIPE_STATS_EN
    ,
    output logic [31:0]        tok_out_cnt,
    output logic [31:0]        stall_cnt,
    output logic [CNT_BW-1:0]  max_occ
`endif
);

    localparam int PTR_BW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_BW-1:0] LAST_PTR = PTR_BW'(DEPTH - 1);
    localparam logic [CNT_BW-1:0] FULL_CNT = CNT_BW'(DEPTH);

    logic [PTR_BW-1:0] wpReg, wpNext;
    logic [PTR_BW-1:0] rpReg, rpNext;
    logic [CNT_BW-1:0] cntReg, cntNext;
    logic              push, pop, memWe;
    logic [DEPTH-1:0][DATA_BW-1:0] slotData;

    // Ready depends only on the registered count, so there is no full-bypass path.
    assign in_ready  = (cntReg != FULL_CNT);
    assign out_valid = (cntReg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign memWe     = push & ~flush & rst;
    assign out_data  = slotData[rpReg];
    assign occupancy = cntReg;

    always_comb begin
        wpNext  = wpReg;
        rpNext  = rpReg;
        cntNext = cntReg;
        if (flush) begin
            wpNext  = '0;
            rpNext  = '0;
            cntNext = '0;
        end else begin
            if (push) wpNext = (wpReg == LAST_PTR) ? '0 : wpReg + 1'b1;
            if (pop)  rpNext = (rpReg == LAST_PTR) ? '0 : rpReg + 1'b1;
            case ({push, pop})
                2'b10:   cntNext = cntReg + 1'b1;
                2'b01:   cntNext = cntReg - 1'b1;
                default: cntNext = cntReg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wpReg  <= '0;
            rpReg  <= '0;
            cntReg <= '0;
        end else begin
            wpReg  <= wpNext;
            rpReg  <= rpNext;
            cntReg <= cntNext;
        end
    end

    // Token slots are never reset; only the pointers decide what is valid.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_slot
            logic [DATA_BW-1:0] slotReg;
            always_ff @(posedge clk) begin
                if (memWe && (wpReg == PTR_BW'(gi))) slotReg <= in_data;
            end
            assign slotData[gi] = slotReg;
        end
    endgenerate

`ifdef HA_TOKEN_PIPE_STATS_EN
    logic [31:0]       tokOutCntReg;
    logic [31:0]       stallCntReg;
    logic [CNT_BW-1:0] maxOccReg;

    // Counters survive flush; the high-water mark keeps tracking the post-flush count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tokOutCntReg <= '0;
            stallCntReg  <= '0;
            maxOccReg    <= '0;
        end else begin
            if (pop && !flush && (tokOutCntReg != '1)) tokOutCntReg <= tokOutCntReg + 1'b1;
            if (out_valid && !out_ready && (stallCntReg != '1)) stallCntReg <= stallCntReg + 1'b1;
            if (cntNext > maxOccReg) maxOccReg <= cntNext;
        end
    end

    assign tok_out_cnt = tokOutCntReg;
    assign stall_cnt   = stallCntReg;
    assign max_occ     = maxOccReg;
`else
    // Core-only build: no statistics state.
`endif

endmodule
